// File: rtl/tim_reg_responder.sv
// Timer peripheral register responder: word-mapped CTRL/PSC/ARR/CNT/STATUS,
// prescaler and counter, level interrupt. Optional ARR shadow via TIM_ARR_PRELOAD_EN.
module tim_reg_responder #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              irq
);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_PSC    = 3'd1;
  localparam logic [2:0] IDX_ARR    = 3'd2;
  localparam logic [2:0] IDX_CNT    = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] arr_q, arr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             uif_q, uif_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [2:0]       idx;
  logic             bad, accept, wr;
  logic             wr_ctrl, wr_psc, wr_arr, wr_cnt, wr_status;
  logic             en, oneshot, irq_en, dir;
  logic             tick_raw, tick, at_limit, upd;
  logic [CNT_W-1:0] wdata_cnt, arr_view;
  logic [31:0]      rd_word;
  logic             unused_wdata;

  assign idx       = req_addr[4:2];
  assign bad       = (|req_addr[1:0]) | (idx > IDX_STATUS) | ((req_addr >> 5) != '0);
  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign wr        = accept & req_we & ~bad;
  assign wr_ctrl   = wr & (idx == IDX_CTRL);
  assign wr_psc    = wr & (idx == IDX_PSC);
  assign wr_arr    = wr & (idx == IDX_ARR);
  assign wr_cnt    = wr & (idx == IDX_CNT);
  assign wr_status = wr & (idx == IDX_STATUS);
  assign wdata_cnt = req_wdata[CNT_W-1:0];
  assign unused_wdata = ^(req_wdata >> CNT_W);

  assign en      = ctrl_q[0];
  assign oneshot = ctrl_q[1];
  assign irq_en  = ctrl_q[2];
  assign dir     = ctrl_q[3];

  // A software write to CTRL, PSC or CNT swallows a coincident tick.
  assign tick_raw = en & (presc_q == psc_q);
  assign tick     = tick_raw & ~(wr_ctrl | wr_psc | wr_cnt);
  assign at_limit = dir ? (cnt_q == '0) : (cnt_q == arr_q);
  assign upd      = tick & at_limit;

  always_comb begin
    presc_d = presc_q;
    if (wr_psc | wr_cnt)
      presc_d = '0;
    else if (en)
      presc_d = tick_raw ? '0 : presc_q + CNT_W'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt)
      cnt_d = wdata_cnt;
    else if (tick) begin
      if (upd)
        cnt_d = dir ? arr_q : '0;
      else
        cnt_d = dir ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl)
      ctrl_d = req_wdata[3:0];
    else if (upd & oneshot)
      ctrl_d = ctrl_q & 4'b1110;
    psc_d = wr_psc ? wdata_cnt : psc_q;
    // Set beats clear when a W1C meets an update event.
    uif_d = (uif_q & ~(wr_status & req_wdata[0])) | upd;
  end

`ifdef TIM_ARR_PRELOAD_EN
  logic [CNT_W-1:0] arr_sh_q, arr_sh_d;

  always_comb begin
    arr_sh_d = wr_arr ? wdata_cnt : arr_sh_q;
    arr_d    = (~en | upd) ? arr_sh_d : arr_q;
  end

  assign arr_view = arr_sh_q;

  always_ff @(posedge clk) begin
    if (reset)
      arr_sh_q <= '0;
    else
      arr_sh_q <= arr_sh_d;
  end
`else
  always_comb begin
    arr_d = wr_arr ? wdata_cnt : arr_q;
  end

  assign arr_view = arr_q;
`endif

  always_comb begin
    rd_word = '0;
    case (idx)
      IDX_CTRL:   rd_word = {28'd0, ctrl_q};
      IDX_PSC:    rd_word = 32'(psc_q);
      IDX_ARR:    rd_word = 32'(arr_view);
      IDX_CNT:    rd_word = 32'(cnt_q);
      IDX_STATUS: rd_word = {31'd0, uif_q};
      default:    rd_word = '0;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = bad;
      rsp_rdata_d = (req_we | bad) ? 32'd0 : rd_word;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= '0;
      psc_q       <= '0;
      arr_q       <= '0;
      cnt_q       <= '0;
      presc_q     <= '0;
      uif_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      psc_q       <= psc_d;
      arr_q       <= arr_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      uif_q       <= uif_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign irq       = uif_q & irq_en;

endmodule

// File: tb/tb_tim_reg_responder.sv
// Self-checking bench for tim_reg_responder: directed scenarios plus random
// traffic, compared every cycle against a behavioural timer model.
module tb_tim_reg_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, irq;
  logic [31:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tim_reg_responder #(.ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .irq(irq)
  );

  localparam int unsigned MASK = 32'h0000_FFFF;

  bit          m_en, m_one, m_ie, m_dir, m_uif, m_rv, m_err;
  int unsigned m_psc, m_arr, m_sh, m_cnt, m_presc;
  logic [31:0] m_rd;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_one = 0; m_ie = 0; m_dir = 0; m_uif = 0;
    m_rv = 0; m_err = 0; m_rd = '0;
    m_psc = 0; m_arr = 0; m_sh = 0; m_cnt = 0; m_presc = 0;
  endtask

  // Advances the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit acc, bad, wr, tick, blocked, evt;
    int unsigned idx, wd, rd, n_cnt, n_presc, n_sh, n_arr;
    if (reset) begin
      model_reset();
      return;
    end
    acc  = req_valid && (!m_rv || rsp_ready);
    idx  = req_addr[4:2];
    bad  = (req_addr[1:0] != 2'b00) || (idx > 4);
    wr   = acc && req_we && !bad;
    wd   = req_wdata & MASK;
    case (idx)
      0: rd = {28'd0, m_dir, m_ie, m_one, m_en};
      1: rd = m_psc;
      2: rd = m_sh;
      3: rd = m_cnt;
      4: rd = {31'd0, m_uif};
      default: rd = 0;
    endcase
    tick    = m_en && (m_presc == m_psc);
    blocked = wr && (idx == 0 || idx == 1 || idx == 3);
    evt     = tick && !blocked && (m_dir ? (m_cnt == 0) : (m_cnt == m_arr));

    n_cnt = m_cnt;
    if (wr && idx == 3) n_cnt = wd;
    else if (tick && !blocked) begin
      if (evt) n_cnt = m_dir ? m_arr : 0;
      else     n_cnt = (m_dir ? (m_cnt + MASK) : (m_cnt + 1)) & MASK;
    end

    n_presc = m_presc;
    if (wr && (idx == 1 || idx == 3)) n_presc = 0;
    else if (m_en) n_presc = tick ? 0 : ((m_presc + 1) & MASK);

    n_sh = (wr && idx == 2) ? wd : m_sh;
`ifdef TIM_ARR_PRELOAD_EN
    n_arr = (!m_en || evt) ? n_sh : m_arr;
`else
    n_arr = n_sh;
`endif

    m_uif = (m_uif && !(wr && idx == 4 && req_wdata[0])) || evt;
    if (wr && idx == 0) begin
      m_en = req_wdata[0]; m_one = req_wdata[1];
      m_ie = req_wdata[2]; m_dir = req_wdata[3];
    end else if (evt && m_one) begin
      m_en = 0;
    end
    if (wr && idx == 1) m_psc = wd;
    m_cnt = n_cnt; m_presc = n_presc; m_sh = n_sh; m_arr = n_arr;

    if (acc) begin
      m_rv  = 1;
      m_err = bad;
      m_rd  = (req_we || bad) ? 32'd0 : rd;
    end else if (rsp_ready) begin
      m_rv = 0;
    end
  endtask

  task automatic step();
    #1;
    check("req_ready", {31'd0, req_ready}, {31'd0, (!m_rv || rsp_ready)});
    model_step();
    @(posedge clk);
    #1;
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
    check("irq", {31'd0, irq}, {31'd0, (m_uif && m_ie)});
    if (m_rv) begin
      check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
      check("rsp_rdata", rsp_rdata, m_rd);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      req_valid = 0; rsp_ready = 1;
      step();
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = d; rsp_ready = 1;
    step();
    req_valid = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] data);
    req_valid = 1; req_we = 0; req_addr = a; req_wdata = '0; rsp_ready = 1;
    step();
    req_valid = 0;
    data = rsp_rdata;
  endtask

  task automatic do_reset();
    reset = 1; req_valid = 0; rsp_ready = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    logic [31:0] v;
    model_reset();
    do_reset();

    for (int i = 0; i < 5; i++) begin
      rd(5'(i * 4), v);
      check("reset_read", v, 32'd0);
      check("reset_err", {31'd0, rsp_err}, 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

    // Up-count with interrupt, then W1C.
    wr(5'd4, 32'd0);
    wr(5'd8, 32'd3);
    wr(5'd0, 32'h5);
    idle(4);
    check("up_irq_set", {31'd0, irq}, 32'd1);
    wr(5'd16, 32'd1);
    check("up_irq_clr", {31'd0, irq}, 32'd0);

    // One-shot with prescaler.
    do_reset();
    wr(5'd4, 32'd2);
    wr(5'd8, 32'd1);
    wr(5'd0, 32'h3);
    idle(20);
    rd(5'd0, v);  check("oneshot_ctrl", v, 32'h2);
    rd(5'd12, v); check("oneshot_cnt", v, 32'd0);
    rd(5'd16, v); check("oneshot_uif", v, 32'd1);

    // Down-count with reload.
    do_reset();
    wr(5'd4, 32'd0);
    wr(5'd8, 32'd5);
    wr(5'd12, 32'd2);
    wr(5'd0, 32'h9);
    idle(4);
    rd(5'd12, v); check("down_cnt", v, 32'd4);
    rd(5'd16, v); check("down_uif", v, 32'd1);

    // Error accesses and response backpressure.
    do_reset();
    wr(5'd4, 32'd7);
    rd(5'd2, v);
    check("err_misalign", {31'd0, rsp_err}, 32'd1);
    check("err_misalign_data", v, 32'd0);
    rd(5'd24, v);
    check("err_unmapped", {31'd0, rsp_err}, 32'd1);
    check("err_unmapped_data", v, 32'd0);
    wr(5'd6, 32'hFF);
    rd(5'd4, v); check("err_no_effect", v, 32'd7);
    req_valid = 1; req_we = 0; req_addr = 5'd4; rsp_ready = 1;
    step();
    req_addr = 5'd12; rsp_ready = 0;
    repeat (3) begin
      step();
      check("hold_ready", {31'd0, req_ready}, 32'd0);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, 32'd7);
    end
    req_valid = 0; rsp_ready = 1;
    step();

    // Coincident W1C/update and CNT write on a tick.
    do_reset();
    wr(5'd4, 32'd0);
    wr(5'd8, 32'd0);
    wr(5'd0, 32'h1);
    idle(2);
    wr(5'd16, 32'd1);
    rd(5'd16, v); check("w1c_vs_set", v, 32'd1);
    wr(5'd8, 32'd100);
    wr(5'd12, 32'd7);
    rd(5'd12, v); check("cnt_write_wins", v, 32'd7);

    // ARR change mid-count; period behaviour depends on the preload build.
    do_reset();
    wr(5'd4, 32'd0);
    wr(5'd8, 32'd3);
    wr(5'd0, 32'h1);
    idle(1);
    wr(5'd8, 32'd9);
    for (int i = 0; i < 24; i++) rd(5'd12, v);
    rd(5'd8, v); check("arr_readback", v, 32'd9);

    // Randomised traffic including occasional mid-transaction reset.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_we    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 85) req_addr = 5'($urandom_range(0, 4) * 4);
      else                            req_addr = 5'($urandom);
      req_wdata = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 0; req_valid = 0; rsp_ready = 1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tim_reg_responder.md
Name: tim_reg_responder

Overview:
- Memory-mapped responder for the timer peripheral. The core's load/store path is the initiator.
- Decodes word-aligned register accesses and holds the CTRL/PSC/ARR/CNT/STATUS registers.
- Runs the prescaler and counter, latches the update flag and drives a level interrupt.
- Sits on the data-memory side of the datapath and replaces hard-wired PSC/ARR/enable signals with software-programmable registers.

Parameters:
- ADDR_W, 5, width of the local byte offset within the peripheral window.
- CNT_W, 16, width of PSC, ARR, CNT and the prescaler counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request present.
- req_ready  out  1  responder can accept the request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte offset.
- req_wdata  in  32  store data; bits above CNT_W are ignored.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data, zero-extended; 0 for stores and errors.
- rsp_err  out  1  access was unaligned or unmapped.
- irq  out  1  UIF & IRQ_EN.

Behaviour:
- Register map (word index = req_addr[4:2]):
  - 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN, bit3 DIR (1 = down).
  - 1 PSC.
  - 2 ARR.
  - 3 CNT (read/write).
  - 4 STATUS: bit0 UIF, write-1-to-clear.
  - Indices 5–7 are unmapped.
- Handshake:
  - req_ready = !rsp_valid | rsp_ready.
  - A request is accepted when req_valid & req_ready.
  - Response appears the next cycle: rsp_valid=1, with rdata/err registered.
  - Response holds stable until rsp_valid & rsp_ready. Back-to-back accepts give one access per cycle.
- Errors:
  - req_addr[1:0] != 0, or an unmapped index, gives rsp_err=1 and rsp_rdata=0.
  - The access has no side effect.
- Store side effects occur on the accept edge:
  - A write to PSC or CNT also clears the prescaler counter.
- Reset values: all registers 0, prescaler counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, irq=0.
- Prescaler, when EN=1:
  - Prescaler counts 0..PSC. A tick is generated when prescaler == PSC, and the prescaler wraps to 0.
  - PSC=0 gives a tick every cycle.
- Counter on a tick, up mode (DIR=0):
  - If CNT == ARR: CNT <= 0 and update event.
  - Otherwise CNT <= CNT+1.
- Counter on a tick, down mode (DIR=1):
  - If CNT == 0: CNT <= ARR and update event.
  - Otherwise CNT <= CNT-1.
- CNT > ARR in up mode counts up to all-ones, wraps to 0, then continues to ARR. No event at the wrap.
- ARR=0: an update event occurs on every tick.
- Update event:
  - UIF <= 1.
  - If ONESHOT, EN <= 0 in the same edge; CNT keeps its wrapped value.
- EN=0: prescaler and CNT freeze and keep their values.
- Simultaneous events:
  - Software write to CNT/PSC/CTRL and a tick in the same cycle: the software write wins, and the tick is dropped.
  - W1C of UIF and an update event in the same cycle: set wins, UIF=1.
- irq is combinational from registered UIF and IRQ_EN. No glitch sources.
- Reset asserted mid-transaction: a pending response is discarded (rsp_valid=0 next cycle), and all registers return to reset values.

Optional Feature:
- Macro: TIM_ARR_PRELOAD_EN.
- When defined:
  - Stores to ARR write a shadow register.
  - Shadow is copied to the active ARR on each update event, or immediately when EN=0.
  - Loads of ARR return the shadow.
  - Comparison/reload use the active ARR.
- When undefined: ARR writes take effect on the next edge, and no shadow exists.

Test Plan:
- Reset, then read all 5 registers → each rsp_rdata=0, rsp_err=0, rsp_valid exactly 1 cycle after accept; irq=0.
- PSC=0, ARR=3, CTRL=0x5 (EN, IRQ_EN, up) → CNT sequence 1,2,3,0; UIF=1 and irq=1 on the edge where CNT wraps to 0; write STATUS=1 → irq=0 next cycle.
- PSC=2, ARR=1, CTRL=0x3 (EN, ONESHOT) → CNT changes every 3 cycles: 1, then 0 with UIF=1 and EN read back 0; CNT stays 0 afterwards.
- DIR=1, ARR=5, CNT=2, PSC=0, EN → CNT 1,0,5,4; UIF set when CNT reloads to 5.
- Load at offset 0x02 and at offset 0x18 → rsp_err=1, rdata=0, no register changes. Hold rsp_ready=0 for 3 cycles → req_ready=0 and the response is stable throughout.
- Same cycle: W1C STATUS while an update event occurs → UIF remains 1. Write CNT=7 on a tick cycle → CNT reads 7. With TIM_ARR_PRELOAD_EN, write ARR=9 mid-count (ARR was 3) → period changes only after the next update.
